// File: rtl/mdu_if.sv
// Handshake bundle between the EX operand muxes and the iterative
// multiply/divide unit.
interface mdu_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             valid;
  logic [WIDTH-1:0] result;

  modport master (
    output start, funct3, a, b, flush,
    input  busy, stall, valid, result
  );

  modport slave (
    input  start, funct3, a, b, flush,
    output busy, stall, valid, result
  );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and
// restoring divide, one bit per cycle, sign fixup on the last edge.
module mdu_iterative #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic rst,
  mdu_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] MIN_S = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LD = CNT_W'(WIDTH);

  state_t             r_state;
  state_t             w_state_nx;
  logic [2:0]         r_f3;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_dvsr;
  logic [WIDTH-1:0]   r_result;

  logic               w_a_sgn;
  logic               w_b_sgn;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_div0;
  logic               w_ovf;
  logic               w_special;
  logic [WIDTH-1:0]   w_spec_res;
  logic               w_launch;
  logic               w_last;
  logic [2*WIDTH-1:0] w_mul_add;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_nx;
  logic [WIDTH-1:0]   w_quo_nx;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;
  logic [WIDTH-1:0]   w_fin;

  // Operand decode, magnitudes and start-time special cases.
  always_comb begin
    w_a_sgn = 1'b0;
    w_b_sgn = 1'b0;
    unique case (bus.funct3)
      3'b000:  begin w_a_sgn = 1'b1; w_b_sgn = 1'b1; end
      3'b001:  begin w_a_sgn = 1'b1; w_b_sgn = 1'b1; end
      3'b010:  begin w_a_sgn = 1'b1; w_b_sgn = 1'b0; end
      3'b100:  begin w_a_sgn = 1'b1; w_b_sgn = 1'b1; end
      3'b110:  begin w_a_sgn = 1'b1; w_b_sgn = 1'b1; end
      default: begin w_a_sgn = 1'b0; w_b_sgn = 1'b0; end
    endcase
    w_sa       = w_a_sgn & bus.a[WIDTH-1];
    w_sb       = w_b_sgn & bus.b[WIDTH-1];
    w_abs_a    = w_sa ? -bus.a : bus.a;
    w_abs_b    = w_sb ? -bus.b : bus.b;
    w_div0     = bus.funct3[2] & (bus.b == '0);
    w_ovf      = bus.funct3[2] & ~bus.funct3[0]
               & (bus.a == MIN_S) & (bus.b == '1);
    w_special  = w_div0 | w_ovf;
    w_spec_res = '0;
    if (w_div0)
      w_spec_res = bus.funct3[1] ? bus.a : '1;
    else
      w_spec_res = bus.funct3[1] ? '0 : bus.a;
    w_launch   = (r_state == S_IDLE) & bus.start & ~bus.flush;
    w_last     = (r_state == S_CALC) & ~bus.flush
               & (r_cnt == CNT_W'(1));
  end

  // One iteration step plus the final sign fixup.
  always_comb begin
    w_mul_add  = r_prod + (r_mplier[0] ? r_mcand : '0);
    w_prod_fix = r_neg_q ? -w_mul_add : w_mul_add;
    w_shift    = {r_rem, r_quo[WIDTH-1]};
    w_diff     = w_shift - {1'b0, r_dvsr};
    w_ge       = ~w_diff[WIDTH];
    w_rem_nx   = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    w_quo_nx   = {r_quo[WIDTH-2:0], w_ge};
    w_q_fix    = r_neg_q ? -w_quo_nx : w_quo_nx;
    w_r_fix    = r_neg_r ? -w_rem_nx : w_rem_nx;
    w_fin      = '0;
    if (r_f3[2])
      w_fin = r_f3[1] ? w_r_fix : w_q_fix;
    else if (r_f3[1:0] == 2'b00)
      w_fin = w_prod_fix[WIDTH-1:0];
    else
      w_fin = w_prod_fix[2*WIDTH-1:WIDTH];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // Next-state logic.
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_launch)
          w_state_nx = w_special ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (bus.flush)
          w_state_nx = S_IDLE;
        else if (r_cnt == CNT_W'(1))
          w_state_nx = S_DONE;
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Operand latch, iteration datapath and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_f3     <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvsr   <= '0;
      r_result <= '0;
    end else if (w_launch) begin
      r_f3 <= bus.funct3;
      if (w_special) begin
        r_result <= w_spec_res;
      end else begin
        r_cnt    <= CNT_LD;
        r_neg_q  <= w_sa ^ w_sb;
        r_neg_r  <= w_sa;
        r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
        r_mplier <= w_abs_b;
        r_prod   <= '0;
        r_quo    <= w_abs_a;
        r_rem    <= '0;
        r_dvsr   <= w_abs_b;
      end
    end else if (r_state == S_CALC && !bus.flush) begin
      r_cnt    <= r_cnt - CNT_W'(1);
      r_prod   <= w_mul_add;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_quo    <= w_quo_nx;
      r_rem    <= w_rem_nx;
      if (w_last)
        r_result <= w_fin;
    end
  end

  assign bus.busy   = (r_state != S_IDLE);
  assign bus.stall  = bus.start | bus.busy;
  assign bus.valid  = (r_state == S_DONE);
  assign bus.result = r_result;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed and random checks of mdu_iterative against an
// arithmetic RV32M reference model.
module tb_mdu_iterative;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  mdu_if #(.WIDTH(32)) bus ();

  mdu_iterative #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mdu(
    input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb, p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    xa  = {{32{a[31]}}, a};
    xb  = {{32{b[31]}}, b};
    case (f3)
      3'd0: begin p = xa * xb; return p[31:0]; end
      3'd1: begin p = xa * xb; return p[63:32]; end
      3'd2: begin p = xa * {32'd0, b}; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(
    input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000
        && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.a      = a;
    bus.b      = b;
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b);
    int          cyc;
    logic [31:0] exp;
    exp = ref_mdu(f3, a, b);
    launch(f3, a, b);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.funct3 = 3'($urandom);
    bus.a      = $urandom;
    bus.b      = $urandom;
    cyc = 1;
    while (!bus.valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, cyc, ref_lat(f3, a, b));
    check({tag, "_res"}, bus.result, exp);
  endtask

  initial begin
    int          cyc;
    int          nbusy;
    int          nstall;
    int          nvalid;
    logic [31:0] keep;
    logic [2:0]  rf3;
    logic [31:0] ra;
    logic [31:0] rb;

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = 3'd0;
    bus.a      = '0;
    bus.b      = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    rst = 1'b0;

    // MUL 7 * -3 with busy/stall profile
    launch(3'd0, 32'd7, 32'hFFFF_FFFD);
    #1;
    check("c0_stall", 32'(bus.stall), 32'd1);
    check("c0_busy", 32'(bus.busy), 32'd0);
    nbusy  = 0;
    nstall = 0;
    cyc    = 0;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.valid && cyc < 40) begin
      if (bus.busy) nbusy++;
      if (bus.stall) nstall++;
      @(negedge clk);
      cyc++;
    end
    if (bus.busy) nbusy++;
    if (bus.stall) nstall++;
    check("mul_lat", cyc, 32'd33);
    check("mul_res", bus.result, 32'hFFFF_FFEB);
    check("mul_busy_cycles", nbusy, 32'd33);
    check("mul_stall_cycles", nstall, 32'd33);
    @(negedge clk);
    check("mul_valid_drop", 32'(bus.valid), 32'd0);
    check("mul_busy_drop", 32'(bus.busy), 32'd0);
    check("mul_stall_drop", 32'(bus.stall), 32'd0);
    check("mul_res_hold", bus.result, 32'hFFFF_FFEB);

    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000);
    check("mulh_val", bus.result, 32'h4000_0000);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulhu_val", bus.result, 32'hFFFF_FFFE);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulhsu_val", bus.result, 32'hFFFF_FFFF);
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2);
    check("div_val", bus.result, 32'hFFFF_FFFD);
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2);
    check("rem_val", bus.result, 32'hFFFF_FFFF);
    run_op("divu", 3'd5, 32'd100, 32'd7);
    check("divu_val", bus.result, 32'd14);
    run_op("remu", 3'd7, 32'd100, 32'd7);
    check("remu_val", bus.result, 32'd2);
    run_op("div0", 3'd4, 32'd5, 32'd0);
    check("div0_val", bus.result, 32'hFFFF_FFFF);
    run_op("remu0", 3'd7, 32'd5, 32'd0);
    check("remu0_val", bus.result, 32'd5);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    check("divovf_val", bus.result, 32'h8000_0000);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    check("removf_val", bus.result, 32'd0);

    // start held high with new operands: only the first op completes
    launch(3'd5, 32'd100, 32'd7);
    nvalid = 0;
    keep   = 32'hDEAD_BEEF;
    for (int i = 0; i < 40 && nvalid == 0; i++) begin
      @(negedge clk);
      bus.funct3 = 3'($urandom);
      bus.a      = $urandom;
      bus.b      = $urandom;
      if (bus.valid) begin
        nvalid++;
        keep      = bus.result;
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid) nvalid++;
    end
    check("hold_nvalid", nvalid, 32'd1);
    check("hold_res", keep, 32'd14);

    // flush at cycle 10
    keep = bus.result;
    launch(3'd0, 32'd9, 32'd9);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd0);
    nvalid = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid) nvalid++;
    end
    check("flush_nvalid", nvalid, 32'd0);
    check("flush_res", bus.result, keep);

    // flush together with start in IDLE drops the start
    launch(3'd0, 32'd2, 32'd2);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flstart_busy", 32'(bus.busy), 32'd0);
    run_op("after_flush", 3'd0, 32'd6, 32'd7);

    // reset at cycle 15 of a DIV
    launch(3'd4, 32'd1000, 32'd3);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy", 32'(bus.busy), 32'd0);
    check("mrst_valid", 32'(bus.valid), 32'd0);
    check("mrst_result", bus.result, 32'd0);
    run_op("mul34", 3'd0, 32'd3, 32'd4);
    check("mul34_val", bus.result, 32'd12);

    // random ops incl. forced corner operands
    for (int i = 0; i < 40; i++) begin
      rf3 = 3'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op($sformatf("rnd%0d_f%0d", i, rf3), rf3, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
